cv32e40p_tmr_vote_monitor: RTL

- Parametrised triple-modular-redundancy voter and fault monitor for replicated core sub-blocks such as the CSR file.
- Votes NUM_CHANNELS independent channels of WIDTH bits each, bit by bit.
- Tracks per-replica disagreement with saturating counters and sticky flags.
- Detects persistently faulty replicas and runs a resync request/acknowledge handshake toward the replica owner.

---
 rtl/cv32e40p_tmr_vote_monitor_if.sv | 27 ++
 rtl/cv32e40p_tmr_vote_monitor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tmr_vote_monitor_if.sv
// Resync handshake between the TMR vote monitor and the owner of the replicas.
//
// Handshake: the monitor raises resync_req_o with resync_id_o naming the replica
// to resynchronise. Both hold steady until resync_ack_i is sampled high on a
// rising clock edge, which completes the transfer. resync_req_o drops on that
// same edge. resync_ack_i is ignored whenever no request is outstanding.
// dbg_state mirrors the monitor FSM (0 IDLE, 1 REQ, 2 SETTLE) for observation only.
interface cv32e40p_tmr_vote_monitor_if;
    logic       resync_req_o;
    logic [1:0] resync_id_o;
    logic       resync_ack_i;
    logic [1:0] dbg_state;

    modport master (
        output resync_req_o,
        output resync_id_o,
        output dbg_state,
        input  resync_ack_i
    );

    modport slave (
        input  resync_req_o,
        input  resync_id_o,
        input  dbg_state,
        output resync_ack_i
    );
endinterface

// File: rtl/cv32e40p_tmr_vote_monitor.sv
// Triple-modular-redundancy voter with per-replica fault tracking.
// The vote is purely combinational. Counters, sticky flags and the resync FSM
// advance on the clock edge. Counting only happens while en_i is high.
module cv32e40p_tmr_vote_monitor #(
    parameter int WIDTH          = 32,
    parameter int NUM_CHANNELS   = 4,
    parameter int CNT_WIDTH      = 8,
    parameter int PERSIST_THRESH = 4,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic [NUM_CHANNELS*WIDTH-1:0] rep0_i,
    input  logic [NUM_CHANNELS*WIDTH-1:0] rep1_i,
    input  logic [NUM_CHANNELS*WIDTH-1:0] rep2_i,
    output logic [NUM_CHANNELS*WIDTH-1:0] voted_o,
    output logic [2:0]                    mismatch_o,
    output logic [NUM_CHANNELS-1:0]       ch_err_o,
    output logic [3*CNT_WIDTH-1:0]        err_cnt_o,
    output logic [2:0]                    fault_o,
    output logic                          multi_err_o,
    input  logic                          clear_i,
    cv32e40p_tmr_vote_monitor_if.master   rs
);

    localparam int VW       = NUM_CHANNELS * WIDTH;
    localparam int CONSEC_W = $clog2(PERSIST_THRESH + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CONSEC_W-1:0]  THRESH  = CONSEC_W'(PERSIST_THRESH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [1:0]            id_q, id_d;
    logic [CNT_WIDTH-1:0]  cnt_q [3];
    logic [CNT_WIDTH-1:0]  cnt_d [3];
    logic [CONSEC_W-1:0]   consec_q [3];
    logic [CONSEC_W-1:0]   consec_d [3];
    logic [VW-1:0]         diff [3];
    logic [NUM_CHANNELS-1:0] ch_diff;
    logic [NUM_CHANNELS-1:0] ch_err_q;
    logic [2:0]            excl;
    logic [2:0]            hit;
    logic [2:0]            fault_q;
    logic                  multi_hit;
    logic                  multi_q;

    // Bitwise majority and per-replica disagreement, independent of all state.
    assign voted_o    = (rep0_i & rep1_i) | (rep0_i & rep2_i) | (rep1_i & rep2_i);
    assign diff[0]    = rep0_i ^ voted_o;
    assign diff[1]    = rep1_i ^ voted_o;
    assign diff[2]    = rep2_i ^ voted_o;
    assign mismatch_o = {|diff[2], |diff[1], |diff[0]};
    // Two or more disagreeing replicas means fewer than two match the vote.
    assign multi_hit  = (mismatch_o[0] & mismatch_o[1]) | (mismatch_o[0] & mismatch_o[2]) |
                        (mismatch_o[1] & mismatch_o[2]);

    // Per-channel disagreement from any replica.
    always_comb begin
        ch_diff = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ch_diff[c] = |(diff[0][c*WIDTH +: WIDTH] | diff[1][c*WIDTH +: WIDTH] |
                           diff[2][c*WIDTH +: WIDTH]);
        end
    end

    // Next counter values; the replica under resync is frozen until SETTLE ends.
    always_comb begin
        excl = '0;
        hit  = '0;
        for (int r = 0; r < 3; r++) begin
            excl[r]     = (state_q != IDLE) && (id_q == 2'(r));
            cnt_d[r]    = cnt_q[r];
            consec_d[r] = consec_q[r];
            if (en_i && !excl[r]) begin
                if (mismatch_o[r]) begin
                    if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + 1'b1;
                    if (consec_q[r] < THRESH) consec_d[r] = consec_q[r] + 1'b1;
                end else begin
                    consec_d[r] = '0;
                end
            end
            if (state_q == REQ && rs.resync_ack_i && id_q == 2'(r)) consec_d[r] = '0;
            hit[r] = (consec_d[r] >= THRESH);
        end
    end

    // Resync FSM next state: request the lowest persistently failing replica.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        id_d     = id_q;
        case (state_q)
            IDLE: begin
                if (en_i && !clear_i && (|hit)) begin
                    state_d = REQ;
                    id_d    = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
                end
            end
            REQ: begin
                if (rs.resync_ack_i) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_W'(SETTLE_CYCLES);
                end
            end
            SETTLE: begin
                if (settle_q <= SETTLE_W'(1)) begin
                    state_d  = IDLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; clear_i deliberately leaves an outstanding resync alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            id_q     <= id_d;
        end
    end

    // Counters and sticky flags; clear_i overrides any update in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            for (int r = 0; r < 3; r++) begin
                cnt_q[r]    <= '0;
                consec_q[r] <= '0;
            end
            ch_err_q <= '0;
            fault_q  <= '0;
            multi_q  <= 1'b0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                cnt_q[r]    <= cnt_d[r];
                consec_q[r] <= consec_d[r];
            end
            if (en_i) begin
                ch_err_q <= ch_err_q | ch_diff;
                multi_q  <= multi_q | multi_hit;
            end
            if (state_q == IDLE && state_d == REQ) fault_q <= fault_q | hit;
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_cnt_out
        assign err_cnt_o[r*CNT_WIDTH +: CNT_WIDTH] = cnt_q[r];
    end

    assign ch_err_o        = ch_err_q;
    assign fault_o         = fault_q;
    assign multi_err_o     = multi_q;
    assign rs.resync_req_o = (state_q == REQ);
    assign rs.resync_id_o  = id_q;
    assign rs.dbg_state    = state_q;

endmodule
